calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Keypad-driven controller that sequences the calculator's combinational ALU. It accumulates decimal digits into operand A and operand B and latches the selected operation. On equals, or on a chained operator, it drives the ALU for one execute cycle and captures the result into the display register. It sits between the key decoder and the ALU. It also owns error handling: divide-by-zero locks the block until clear.

## Interface
- WIDTH, 8, operand/result width; must match the ALU instance.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- digit_valid  in  1  digit key strobe, one cycle per key.
- digit  in  4  digit value; values above 9 are ignored.
- op_valid  in  1  operator key strobe.
- op_sel  in  2  operator code: 00 add, 01 sub, 10 mul, 11 div.
- eq_valid  in  1  equals key strobe.
- clr_valid  in  1  clear key strobe; always accepted.
- key_ready  out  1  high when digit/op/eq strobes are accepted.
- alu_a  out  WIDTH  registered ALU operand A.
- alu_b  out  WIDTH  registered ALU operand B.
- alu_op  out  2  registered ALU op code.
- alu_result  in  WIDTH  combinational result from the ALU.
- display  out  WIDTH  value to show: operand being entered, or last result.
- err  out  1  divide-by-zero error flag; sticky until clr or rst.

## Operation
- States:
  - ENTER_A: building A.
  - OP_WAIT: operator latched, B not started.
  - ENTER_B: building B.
  - EXEC: ALU evaluation.
  - RESULT: result shown.
  - ERROR: locked.
- Priority within one cycle: rst > clr_valid > eq_valid > op_valid > digit_valid. Only the highest-priority strobe acts; the others are dropped.
- Digit accumulate: reg = (reg*10 + digit) mod 2^WIDTH. No overflow flag. display follows the register being built.
- ENTER_A:
  - digit: accumulate into A.
  - op: latch op, clear B, go to OP_WAIT.
  - eq: ignored.
- OP_WAIT:
  - digit: B = digit, go to ENTER_B.
  - op: replace the latched op.
  - eq: ignored.
  - display keeps A.
- ENTER_B:
  - digit: accumulate into B.
  - eq: go to EXEC, no pending op.
  - op: go to EXEC and store op_sel as the pending chained op.
- On entering EXEC: alu_a = A, alu_b = B, alu_op = latched op.
- EXEC lasts exactly one cycle. At its closing edge:
  - If alu_op = 11 and alu_b = 0: err = 1, display = 0, go to ERROR.
  - Otherwise A = alu_result and display = alu_result.
  - With a pending chained op: latch it, clear B, go to OP_WAIT.
  - Without one: go to RESULT.
- RESULT:
  - digit: A = digit, go to ENTER_A (new calculation).
  - op: latch op, clear B, go to OP_WAIT (result becomes A).
  - eq: ignored.
- ERROR: only clr_valid or rst exits.
- Arithmetic width: the ALU wraps modulo 2^WIDTH. The controller neither extends nor saturates results.
- clr_valid in any state, including EXEC and ERROR:
  - A = B = 0, op = 00, err = 0, display = 0, go to ENTER_A.
  - A result in flight is discarded.

## Timing
- Reset values: display 0, err 0, key_ready 1, alu_a 0, alu_b 0, alu_op 00; state ENTER_A; A, B and pending op cleared.
- key_ready = 0 only in EXEC. Strobes other than clr during EXEC are dropped, with no buffering.
- Equals accepted at edge N:
  - cycle N+1: state EXEC, alu_* valid.
  - edge N+1: result captured.
  - cycle N+2: display and err updated, key_ready back to 1.
- ALU path is combinational within the EXEC cycle. alu_* remain stable outside EXEC and hold their last values.
- Digit or op accepted at edge N: display or register updated in cycle N+1.
- rst mid-EXEC: result discarded, all outputs at reset values the next cycle.

## Test plan
- Add: rst, then keys 1,2,+,7,=. Required: display 12 after "2". EXEC is one cycle with alu_a=12, alu_b=7, alu_op=00. display 19 two cycles after "=", state RESULT.
- Chained ops: 5,*,3,+,2,=.
  - The "+" triggers EXEC(15); display 15, state OP_WAIT.
  - Final display 17.
- Wrap-around:
  - 2,0,0,+,1,0,0,= gives 44 (300 mod 256).
  - Digits 2,5,6 give A = 0.
  - 3,-,5,= gives 254.
- Divide by zero: 9,/,0,=. Required:
  - err = 1 and display = 0 two cycles after "=".
  - Further digit/op/eq have no effect.
  - clr returns err = 0, display = 0, state ENTER_A.
  - A following 8,/,2,= gives 4.
- Simultaneous strobes: clr_valid with digit_valid=1 (digit 7) gives display 0. eq_valid with op_valid in ENTER_B acts as equals only; no chained op is latched.
- Busy drop and reset: a digit strobe during EXEC (key_ready=0) is ignored. rst asserted during EXEC gives all outputs at reset values the next cycle; the result is never displayed.

Source files
------------

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven sequencer that builds operands and drives a combinational ALU
module calc_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             digit_valid,
    input  logic [3:0]       digit,
    input  logic             op_valid,
    input  logic [1:0]       op_sel,
    input  logic             eq_valid,
    input  logic             clr_valid,
    output logic             key_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] display,
    output logic             err
);
    typedef enum logic [2:0] {ENTER_A, OP_WAIT, ENTER_B, EXEC, RESULT, ERROR} state_t;

    state_t state, state_n;
    logic [WIDTH-1:0] a, a_n, b, b_n, alu_a_n, alu_b_n, display_n, dig_w, acc_a, acc_b;
    logic [1:0] op, op_n, pend_op, pend_op_n, alu_op_n;
    logic pend, pend_n, err_n, dig_ok;

    assign dig_ok    = digit_valid && digit <= 4'd9;
    assign dig_w     = WIDTH'(digit);
    assign acc_a     = (a << 3) + (a << 1) + dig_w;
    assign acc_b     = (b << 3) + (b << 1) + dig_w;
    assign key_ready = state != EXEC;

    // Next-state and datapath updates; only the highest-priority strobe acts
    always_comb begin
        state_n   = state;
        a_n       = a;
        b_n       = b;
        op_n      = op;
        pend_n    = pend;
        pend_op_n = pend_op;
        alu_a_n   = alu_a;
        alu_b_n   = alu_b;
        alu_op_n  = alu_op;
        display_n = display;
        err_n     = err;
        if (clr_valid) begin
            state_n   = ENTER_A;
            a_n       = '0;
            b_n       = '0;
            op_n      = 2'b00;
            pend_n    = 1'b0;
            pend_op_n = 2'b00;
            display_n = '0;
            err_n     = 1'b0;
        end else begin
            case (state)
                ENTER_A: begin
                    if (!eq_valid && op_valid) begin
                        op_n    = op_sel;
                        b_n     = '0;
                        state_n = OP_WAIT;
                    end else if (!eq_valid && dig_ok) begin
                        a_n       = acc_a;
                        display_n = acc_a;
                    end
                end
                OP_WAIT: begin
                    if (!eq_valid && op_valid) begin
                        op_n = op_sel;
                    end else if (!eq_valid && dig_ok) begin
                        b_n       = dig_w;
                        display_n = dig_w;
                        state_n   = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (eq_valid || op_valid) begin
                        alu_a_n   = a;
                        alu_b_n   = b;
                        alu_op_n  = op;
                        pend_n    = !eq_valid;
                        pend_op_n = op_sel;
                        state_n   = EXEC;
                    end else if (dig_ok) begin
                        b_n       = acc_b;
                        display_n = acc_b;
                    end
                end
                EXEC: begin
                    if (alu_op == 2'b11 && alu_b == '0) begin
                        err_n     = 1'b1;
                        display_n = '0;
                        state_n   = ERROR;
                    end else begin
                        a_n       = alu_result;
                        display_n = alu_result;
                        op_n      = pend ? pend_op : op;
                        b_n       = pend ? '0 : b;
                        state_n   = pend ? OP_WAIT : RESULT;
                    end
                    pend_n = 1'b0;
                end
                RESULT: begin
                    if (!eq_valid && op_valid) begin
                        op_n    = op_sel;
                        b_n     = '0;
                        state_n = OP_WAIT;
                    end else if (!eq_valid && dig_ok) begin
                        a_n       = dig_w;
                        display_n = dig_w;
                        state_n   = ENTER_A;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and register update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ENTER_A;
            a       <= '0;
            b       <= '0;
            op      <= 2'b00;
            pend    <= 1'b0;
            pend_op <= 2'b00;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= 2'b00;
            display <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            a       <= a_n;
            b       <= b_n;
            op      <= op_n;
            pend    <= pend_n;
            pend_op <= pend_op_n;
            alu_a   <= alu_a_n;
            alu_b   <= alu_b_n;
            alu_op  <= alu_op_n;
            display <= display_n;
            err     <= err_n;
        end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: table-driven directed test of calc_sequencer with a behavioural ALU
module tb_calc_sequencer;
    logic       clk = 1'b0;
    logic       rst, digit_valid, op_valid, eq_valid, clr_valid, key_ready, err;
    logic [3:0] digit;
    logic [1:0] op_sel, alu_op;
    logic [7:0] alu_a, alu_b, alu_result, display;
    int         checks = 0;
    int         errors = 0;

    typedef struct packed {
        logic       r, c, e, ov;
        logic [1:0] os;
        logic       dv;
        logic [3:0] dg;
        logic [7:0] ed;
        logic       ee, er, ca;
        logic [7:0] ea, eb;
        logic [1:0] eo;
    } vec_t;

    vec_t tbl[$];

    calc_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
        .op_valid(op_valid), .op_sel(op_sel), .eq_valid(eq_valid), .clr_valid(clr_valid),
        .key_ready(key_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .display(display), .err(err)
    );

    // Reference ALU: wraps modulo 256, divide by zero yields 0
    always_comb begin
        alu_result = 8'd0;
        case (alu_op)
            2'b00: alu_result = alu_a + alu_b;
            2'b01: alu_result = alu_a - alu_b;
            2'b10: alu_result = alu_a * alu_b;
            default: alu_result = (alu_b == 8'd0) ? 8'd0 : alu_a / alu_b;
        endcase
    end

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, c, e, ov, logic [1:0] os, logic dv, logic [3:0] dg,
                                logic [7:0] ed, logic ee, er, ca, logic [7:0] ea, eb, logic [1:0] eo);
        return '{r: r, c: c, e: e, ov: ov, os: os, dv: dv, dg: dg, ed: ed, ee: ee, er: er, ca: ca,
                 ea: ea, eb: eb, eo: eo};
    endfunction

    function automatic vec_t kr();
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    endfunction
    function automatic vec_t kc();
        return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    endfunction
    function automatic vec_t kd(logic [3:0] d, logic [7:0] ed);
        return mk(0, 0, 0, 0, 0, 1, d, ed, 0, 1, 0, 0, 0, 0);
    endfunction
    function automatic vec_t ko(logic [1:0] s, logic [7:0] ed);
        return mk(0, 0, 0, 1, s, 0, 0, ed, 0, 1, 0, 0, 0, 0);
    endfunction
    function automatic vec_t ki(logic [7:0] ed);
        return mk(0, 0, 0, 0, 0, 0, 0, ed, 0, 1, 0, 0, 0, 0);
    endfunction
    function automatic vec_t ke(logic [7:0] ea, eb, logic [1:0] eo, logic [7:0] ed);
        return mk(0, 0, 1, 0, 0, 0, 0, ed, 0, 0, 1, ea, eb, eo);
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        @(negedge clk);
        rst = v.r; clr_valid = v.c; eq_valid = v.e; op_valid = v.ov; op_sel = v.os;
        digit_valid = v.dv; digit = v.dg;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; clr_valid = 0; eq_valid = 0; op_valid = 0; op_sel = 0; digit_valid = 0; digit = 0;
        tbl = {kr(),
               kd(1, 1), kd(2, 12), ko(0, 12), kd(7, 7), ke(12, 7, 0, 7),
               mk(0, 0, 0, 0, 0, 0, 0, 19, 0, 1, 1, 12, 7, 0), kc(),
               kd(5, 5), ko(2, 5), kd(3, 3), mk(0, 0, 0, 1, 0, 0, 0, 3, 0, 0, 1, 5, 3, 2), ki(15),
               mk(0, 0, 1, 0, 0, 0, 0, 15, 0, 1, 0, 0, 0, 0), kd(2, 2), ke(15, 2, 0, 2), ki(17), kc(),
               kd(2, 2), kd(0, 20), kd(0, 200), ko(0, 200), kd(1, 1), kd(0, 10), kd(0, 100),
               ke(200, 100, 0, 100), ki(44), kc(),
               kd(2, 2), kd(5, 25), kd(6, 0), kd(12, 0), kd(3, 3), kc(),
               kd(3, 3), ko(1, 3), kd(5, 5), ke(3, 5, 1, 5), ki(254),
               kd(4, 4), ko(0, 4), kd(1, 1), ke(4, 1, 0, 1), ki(5), kc(),
               kd(9, 9), ko(3, 9), kd(0, 0), ke(9, 0, 3, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 9, 0, 3),
               mk(0, 0, 0, 0, 0, 1, 5, 0, 1, 1, 1, 9, 0, 3),
               mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 9, 0, 3),
               mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 9, 0, 3), kc(),
               kd(8, 8), ko(3, 8), kd(2, 2), ke(8, 2, 3, 2), ki(4),
               mk(0, 1, 0, 0, 0, 1, 7, 0, 0, 1, 0, 0, 0, 0),
               kd(6, 6), ko(0, 6), kd(3, 3), mk(0, 0, 1, 1, 2, 0, 0, 3, 0, 0, 1, 6, 3, 0), ki(9),
               kd(2, 2), kd(3, 23), mk(0, 0, 1, 0, 0, 0, 0, 23, 0, 1, 1, 6, 3, 0),
               mk(0, 0, 0, 1, 0, 1, 5, 23, 0, 1, 0, 0, 0, 0), kd(1, 1), ke(23, 1, 0, 1), ki(24), kc(),
               kd(4, 4), ko(0, 4), kd(4, 4), ke(4, 4, 0, 4),
               mk(0, 0, 0, 0, 0, 1, 9, 8, 0, 1, 0, 0, 0, 0), kd(1, 1), kc(),
               kd(7, 7), ko(0, 7), kd(1, 1), ke(7, 1, 0, 1), kr(), ki(0), kd(2, 2), kc(),
               kd(3, 3), ko(0, 3), kd(3, 3), ke(3, 3, 0, 3), kc(), ki(0), kd(5, 5)};
        foreach (tbl[i]) begin
            apply(tbl[i]);
            chk("display", i, 32'(display), 32'(tbl[i].ed));
            chk("err", i, 32'(err), 32'(tbl[i].ee));
            chk("key_ready", i, 32'(key_ready), 32'(tbl[i].er));
            if (tbl[i].ca) begin
                chk("alu_a", i, 32'(alu_a), 32'(tbl[i].ea));
                chk("alu_b", i, 32'(alu_b), 32'(tbl[i].eb));
                chk("alu_op", i, 32'(alu_op), 32'(tbl[i].eo));
            end
        end
        // Multiply, then measure the busy window with a bounded wait
        apply(kc());
        apply(kd(2, 2));
        apply(ko(2, 2));
        apply(kd(3, 3));
        apply(ke(2, 3, 2, 3));
        chk("busy_low", 0, 32'(key_ready), 32'd0);
        n = 0;
        while (!key_ready && n < 5) begin
            apply(ki(0));
            n++;
        end
        chk("exec_cycles", 0, 32'(n), 32'd1);
        chk("mul_result", 0, 32'(display), 32'd6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
